// File: rtl/tshoot_pkg.sv
// Shared types and sizes for the ROM download / game read arbiter.
package tshoot_pkg;

  localparam int unsigned AddrW     = 17;
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned FifoPtrW  = $clog2(FifoDepth);
  localparam int unsigned FifoCntW  = FifoPtrW + 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    RdIdle,
    RdIssue,
    RdWait
  } rd_state_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
  } wr_ent_t;

endpackage

// File: rtl/tshoot_wr_fifo.sv
// Small write FIFO holding download bytes (address + data) until the memory port takes them.
module tshoot_wr_fifo
  import tshoot_pkg::*;
(
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    push_i,
  input  wr_ent_t push_data_i,
  input  logic    pop_i,
  output wr_ent_t head_o,
  output logic    full_o,
  output logic    empty_o,
  output logic    ovf_o
);

  wr_ent_t               ent_q [FifoDepth];
  wr_ent_t               ent_d [FifoDepth];
  logic [FifoPtrW-1:0]   wptr_q, wptr_d;
  logic [FifoPtrW-1:0]   rptr_q, rptr_d;
  logic [FifoCntW-1:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == FifoCntW'(FifoDepth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = ent_q[rptr_q];
  assign ovf_o   = ovf_q;

  // A push into a full FIFO still lands when the head is popped in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    ent_d = ent_q;
    if (do_push) begin
      ent_d[wptr_q] = push_data_i;
    end
    wptr_d = wptr_q + FifoPtrW'(do_push);
    rptr_d = rptr_q + FifoPtrW'(do_pop);
    cnt_d  = cnt_q + FifoCntW'(do_push) - FifoCntW'(do_pop);
    ovf_d  = ovf_q | (push_i && !do_push);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FifoDepth; i++) begin
        ent_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/tshoot_rom_arb.sv
// Arbitrates one memory port between HPS ROM download writes and game core reads.
// Optional ROM byte checksum outputs are enabled with `define TSHOOT_ROM_SUM_EN.
module tshoot_rom_arb
  import tshoot_pkg::*;
#(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [AddrW-1:0] ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic             game_rd_req,
  input  logic [AddrW-1:0] game_addr,
  output logic             game_rd_ack,
  output logic [7:0]       game_dout,
  output logic             game_reset,
  output logic [AddrW-1:0] mem_addr,
  output logic [7:0]       mem_din,
  output logic             mem_we,
  output logic             mem_rd,
  input  logic [7:0]       mem_dout,
  output logic             wr_ovf
`ifdef TSHOOT_ROM_SUM_EN
  ,
  output logic [15:0]      rom_sum,
  output logic             sum_valid
`endif
);

  localparam logic [7:0] HoldLast = 8'(HOLD_CYC - 1);
  localparam logic [2:0] LatLast  = 3'(RD_LAT);

  state_e           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic [2:0]       lat_q, lat_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic             pend_v_q, pend_v_d;
  logic [AddrW-1:0] pend_addr_q, pend_addr_d;
  logic             ack_q, ack_d;
  logic [7:0]       dout_q, dout_d;
  logic [AddrW-1:0] mem_addr_q;
  logic [7:0]       mem_din_q;

  logic             fifo_push, fifo_pop, fifo_empty, unused_fifo_full;
  wr_ent_t          fifo_in, fifo_head;
  logic             run_ok;

  assign fifo_push = ioctl_wr && (state_q != S_RUN);
  assign fifo_in   = '{addr: ioctl_addr, data: ioctl_dout};
  assign fifo_pop  = !fifo_empty;

  tshoot_wr_fifo u_wr_fifo (
    .clk_i       (clk_sys),
    .reset_i     (reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (unused_fifo_full),
    .empty_o     (fifo_empty),
    .ovf_o       (wr_ovf)
  );

  // Top-level state: download, post-download hold, game running.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      S_LOAD: begin
        hold_cnt_d = '0;
        if (!ioctl_download && fifo_empty) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ioctl_download) begin
          state_d    = S_LOAD;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (ioctl_download) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // A rising download kills the read path immediately so no stale ack escapes.
  assign run_ok = (state_q == S_RUN) && !ioctl_download;

  always_comb begin
    rd_state_d  = rd_state_q;
    lat_d       = lat_q;
    rd_addr_d   = rd_addr_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    ack_d       = 1'b0;
    dout_d      = dout_q;
    if (!run_ok) begin
      rd_state_d = RdIdle;
      lat_d      = '0;
      pend_v_d   = 1'b0;
    end else begin
      unique case (rd_state_q)
        RdIdle: begin
          if (pend_v_q) begin
            rd_state_d = RdIssue;
            rd_addr_d  = pend_addr_q;
            pend_v_d   = game_rd_req;
            if (game_rd_req) pend_addr_d = game_addr;
          end else if (game_rd_req) begin
            rd_state_d = RdIssue;
            rd_addr_d  = game_addr;
          end
        end
        RdIssue: begin
          rd_state_d = RdWait;
          lat_d      = 3'd1;
        end
        RdWait: begin
          if (lat_q == LatLast) begin
            rd_state_d = RdIdle;
            dout_d     = mem_dout;
            ack_d      = 1'b1;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        default: rd_state_d = RdIdle;
      endcase
      if (rd_state_q != RdIdle && game_rd_req && !pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_addr_d = game_addr;
      end
    end
  end

  assign mem_we   = !fifo_empty;
  assign mem_rd   = (rd_state_q == RdIssue) && !mem_we;
  assign mem_addr = mem_we ? fifo_head.addr : (mem_rd ? rd_addr_q : mem_addr_q);
  assign mem_din  = mem_we ? fifo_head.data : mem_din_q;

  assign game_reset  = (state_q != S_RUN);
  assign game_rd_ack = ack_q;
  assign game_dout   = dout_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_LOAD;
      hold_cnt_q  <= '0;
      rd_state_q  <= RdIdle;
      lat_q       <= '0;
      rd_addr_q   <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      ack_q       <= 1'b0;
      dout_q      <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rd_state_q  <= rd_state_d;
      lat_q       <= lat_d;
      rd_addr_q   <= rd_addr_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      ack_q       <= ack_d;
      dout_q      <= dout_d;
      mem_addr_q  <= mem_addr;
      mem_din_q   <= mem_din;
    end
  end

`ifdef TSHOOT_ROM_SUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q != S_LOAD && state_d == S_LOAD) begin
      sum_d = '0;
    end else if (mem_we) begin
      sum_d = sum_q + 16'(mem_din);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign rom_sum   = sum_q;
  assign sum_valid = (state_q != S_LOAD);
`endif

endmodule

// File: tb/tb_tshoot_rom_arb.sv
// Directed bench for tshoot_rom_arb: download, hold, reads, abort, reset, FIFO overflow, checksum.
module tb_tshoot_rom_arb;
  import tshoot_pkg::*;

  localparam int RdLat = 2;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr, game_rd_req;
  logic [16:0] ioctl_addr, game_addr, mem_addr;
  logic [7:0]  ioctl_dout, mem_din, mem_dout, game_dout;
  logic        game_rd_ack, game_reset, mem_we, mem_rd, wr_ovf;
`ifdef TSHOOT_ROM_SUM_EN
  logic [15:0] rom_sum;
  logic        sum_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  tshoot_rom_arb #(.RD_LAT(RdLat), .HOLD_CYC(16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .game_rd_req    (game_rd_req),
    .game_addr      (game_addr),
    .game_rd_ack    (game_rd_ack),
    .game_dout      (game_dout),
    .game_reset     (game_reset),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_rd         (mem_rd),
    .mem_dout       (mem_dout),
    .wr_ovf         (wr_ovf)
`ifdef TSHOOT_ROM_SUM_EN
    ,
    .rom_sum        (rom_sum),
    .sum_valid      (sum_valid)
`endif
  );

  // Stand-alone FIFO whose pop is under bench control, so it can be stalled into overflow.
  logic    f_rst, f_push, f_pop, f_full, f_empty, f_ovf;
  wr_ent_t f_data, f_head;

  tshoot_wr_fifo u_fifo (
    .clk_i       (clk_sys),
    .reset_i     (f_rst),
    .push_i      (f_push),
    .push_data_i (f_data),
    .pop_i       (f_pop),
    .head_o      (f_head),
    .full_o      (f_full),
    .empty_o     (f_empty),
    .ovf_o       (f_ovf)
  );

  // Memory model: writes land on the edge, read data appears RdLat cycles after mem_rd.
  logic [7:0]  mem [0:131071];
  logic [16:0] rpipe [RdLat];

  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    rpipe[0] <= mem_addr;
    for (int i = 1; i < RdLat; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_dout = mem[rpipe[RdLat-1]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        dl;
    logic        wr;
    logic [16:0] waddr;
    logic [7:0]  wdata;
    logic        e_we;
    logic [16:0] e_addr;
    logic [7:0]  e_din;
    logic        e_greset;
  } vec_t;

  vec_t tbl [22];

  initial begin
    // Rows 0-3: three bytes one per cycle, then download drops; rows 5-20 are the hold window.
    for (int k = 0; k < 22; k++) tbl[k] = '{1'b0, 1'b0, 17'h0, 8'h0, 1'b0, 17'h1FFFF, 8'h33, k < 21};
    tbl[0] = '{1'b1, 1'b1, 17'h00000, 8'h11, 1'b0, 17'h00000, 8'h00, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 17'h00001, 8'h22, 1'b1, 17'h00000, 8'h11, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 17'h1FFFF, 8'h33, 1'b1, 17'h00001, 8'h22, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 17'h00000, 8'h00, 1'b1, 17'h1FFFF, 8'h33, 1'b1};

    reset = 1'b1; ioctl_download = 1'b1; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    game_rd_req = 1'b0; game_addr = '0;
    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_data = '0;

    @(negedge clk_sys);
    chk("rst_game_reset", game_reset, 1);
    chk("rst_ack", game_rd_ack, 0);
    chk("rst_dout", game_dout, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_ovf", wr_ovf, 0);
    reset = 1'b0;

    for (int k = 0; k < 22; k++) begin
      chk($sformatf("v%0d_we", k), mem_we, tbl[k].e_we);
      chk($sformatf("v%0d_addr", k), mem_addr, tbl[k].e_addr);
      chk($sformatf("v%0d_din", k), mem_din, tbl[k].e_din);
      chk($sformatf("v%0d_greset", k), game_reset, tbl[k].e_greset);
      chk($sformatf("v%0d_rd", k), mem_rd, 0);
      chk($sformatf("v%0d_ovf", k), wr_ovf, 0);
      ioctl_download = tbl[k].dl;
      ioctl_wr       = tbl[k].wr;
      ioctl_addr     = tbl[k].waddr;
      ioctl_dout     = tbl[k].wdata;
      @(negedge clk_sys);
    end

    // Single read of 0x00001: mem_rd at +1, ack at +RdLat+2.
    game_rd_req = 1'b1; game_addr = 17'h00001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_sys);
      game_rd_req = 1'b0;
      chk($sformatf("r1_rd%0d", k), mem_rd, k == 1);
      chk($sformatf("r1_ack%0d", k), game_rd_ack, k == RdLat + 2);
      if (k == 1) chk("r1_addr", mem_addr, 17'h00001);
      if (k >= RdLat + 2) chk($sformatf("r1_dout%0d", k), game_dout, 8'h22);
    end

    // Back-to-back reads, a third request hits a full pending slot and is dropped.
    game_rd_req = 1'b1; game_addr = 17'h00000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_sys);
      game_rd_req = (k <= 2);
      game_addr   = (k == 1) ? 17'h1FFFF : 17'h00001;
      chk($sformatf("r2_rd%0d", k), mem_rd, (k == 1) || (k == 5));
      chk($sformatf("r2_ack%0d", k), game_rd_ack, (k == 4) || (k == 8));
      if (k == 1) chk("r2_addr_a", mem_addr, 17'h00000);
      if (k == 5) chk("r2_addr_b", mem_addr, 17'h1FFFF);
      if (k == 4) chk("r2_dout_a", game_dout, 8'h11);
      if (k == 8) chk("r2_dout_b", game_dout, 8'h33);
    end
    game_rd_req = 1'b0;

    // Download restarts while a read is in flight.
    game_rd_req = 1'b1; game_addr = 17'h00001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_sys);
      game_rd_req = 1'b0;
      ioctl_wr = 1'b0;
      chk($sformatf("ab_ack%0d", k), game_rd_ack, 0);
      if (k == 1) chk("ab_rd", mem_rd, 1);
      if (k == 2) begin
        chk("ab_greset_pre", game_reset, 0);
        ioctl_download = 1'b1;
      end
      if (k == 3) begin
        chk("ab_greset", game_reset, 1);
        ioctl_wr = 1'b1; ioctl_addr = 17'h00005; ioctl_dout = 8'h5A;
      end
      if (k == 4) begin
        chk("ab_we", mem_we, 1);
        chk("ab_addr", mem_addr, 17'h00005);
        chk("ab_din", mem_din, 8'h5A);
      end
      if (k == 6) begin
        chk("ab_dout_held", game_dout, 8'h33);
        chk("ab_mem5", mem[5], 8'h5A);
      end
    end

    // Reset on the same edge as a push discards the byte; the next byte goes through.
    ioctl_wr = 1'b1; ioctl_addr = 17'h00007; ioctl_dout = 8'h77; reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("mr_we", mem_we, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_din", mem_din, 0);
    chk("mr_greset", game_reset, 1);
    ioctl_addr = 17'h00008; ioctl_dout = 8'h88;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk("mr_we2", mem_we, 1);
    chk("mr_addr2", mem_addr, 17'h00008);
    chk("mr_din2", mem_din, 8'h88);
    @(negedge clk_sys);
    chk("mr_we3", mem_we, 0);
    chk("mr_ovf", wr_ovf, 0);

    // Stalled FIFO: fill, push+pop on full, then overflow and stickiness.
    f_rst = 1'b0;
    f_push = 1'b1; f_data = '{addr: 17'h10, data: 8'hA1};
    chk("f_empty0", f_empty, 1);
    @(negedge clk_sys);
    f_data = '{addr: 17'h11, data: 8'hB2};
    chk("f_empty1", f_empty, 0);
    chk("f_head1", f_head, {17'h10, 8'hA1});
    @(negedge clk_sys);
    f_data = '{addr: 17'h12, data: 8'hC3}; f_pop = 1'b1;
    chk("f_full2", f_full, 1);
    chk("f_ovf2", f_ovf, 0);
    @(negedge clk_sys);
    f_data = '{addr: 17'h13, data: 8'hD4}; f_pop = 1'b0;
    chk("f_full3", f_full, 1);
    chk("f_ovf3", f_ovf, 0);
    chk("f_head3", f_head, {17'h11, 8'hB2});
    @(negedge clk_sys);
    f_push = 1'b0;
    chk("f_ovf4", f_ovf, 1);
    chk("f_head4", f_head, {17'h11, 8'hB2});
    f_pop = 1'b1;
    @(negedge clk_sys);
    chk("f_head5", f_head, {17'h12, 8'hC3});
    @(negedge clk_sys);
    f_pop = 1'b0;
    chk("f_empty6", f_empty, 1);
    chk("f_ovf6", f_ovf, 1);
    f_rst = 1'b1;
    @(negedge clk_sys);
    f_rst = 1'b0;
    chk("f_ovf_rst", f_ovf, 0);

`ifdef TSHOOT_ROM_SUM_EN
    begin
      logic [15:0] exp_sum;
      int          w;
      exp_sum = '0;
      reset = 1'b1; ioctl_download = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      for (int i = 0; i < 258; i++) begin
        ioctl_wr = 1'b1; ioctl_addr = 17'(i); ioctl_dout = 8'hFF;
        exp_sum = exp_sum + 16'hFF;
        @(negedge clk_sys);
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      chk("sum_valid_load", sum_valid, 0);
      w = 0;
      while (!sum_valid && w < 8) begin
        @(negedge clk_sys);
        w++;
      end
      chk("sum_valid_hold", sum_valid, 1);
      chk("sum_greset", game_reset, 1);
      chk("rom_sum", rom_sum, exp_sum);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
